// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: operation codes, sizes and
// the execute-stage (E) register bundle.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_FLIP = 3'b101,
        ALU_LSR  = 3'b110,
        ALU_LSL  = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic              valid;
        alu_op_t           op;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } e_stage_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction issue handshake: upstream (master) offers an instruction,
// the issue stage (slave) returns instr_ready.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs1;
    logic [REG_AW-1:0] instr_rs2;
    logic              instr_use_imm;
    logic [DATA_W-1:0] instr_imm;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1,
        output instr_rs2, instr_use_imm, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1,
        input  instr_rs2, instr_use_imm, instr_imm,
        output instr_ready
    );

endinterface

// File: rtl/alu_issue_stage_regfile.sv
// 8x16 register file, r0 hardwired to zero, synchronous active-low reset.
// Ports: two operand reads (ra1/ra2), async debug read (da), one write.
module regfile_8x16
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [REG_AW-1:0] da,
    output logic [DATA_W-1:0] dd,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we && wa != '0) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];
    assign dd  = (da  == '0) ? '0 : mem_q[da];

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: reads operands, holds the execute register E that feeds
// an external combinational ALU, and commits its result to the register file.
// Ports: clk/rst_n, instr (issue handshake), stall, alu_in1/alu_in2/alu_sel,
// alu_result, wb_valid/wb_rd/wb_data, retire_cnt, dbg_addr/dbg_data.
// Build option: ALU_ISSUE_FWD_EN forwards alu_result instead of interlocking.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   instr,
    input  logic               stall,
    output logic [DATA_W-1:0]  alu_in1,
    output logic [DATA_W-1:0]  alu_in2,
    output logic [2:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic [15:0]        retire_cnt,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    e_stage_t          e_q, e_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [15:0]       retire_q, retire_d;

    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic [DATA_W-1:0] op1, op2;
    logic              rs1_hit, rs2_hit;
    logic              hazard, accept, commit;

    regfile_8x16 u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (instr.instr_rs1),
        .rd1   (rs1_data),
        .ra2   (instr.instr_rs2),
        .rd2   (rs2_data),
        .da    (dbg_addr),
        .dd    (dbg_data),
        .we    (commit),
        .wa    (e_q.rd),
        .wd    (alu_result)
    );

    // A source depends on the instruction still sitting in E.
    assign rs1_hit = e_q.valid && (e_q.rd != '0)
                     && (instr.instr_rs1 == e_q.rd);
    assign rs2_hit = e_q.valid && (e_q.rd != '0)
                     && !instr.instr_use_imm
                     && (instr.instr_rs2 == e_q.rd);

`ifdef ALU_ISSUE_FWD_EN
    // Accept implies !stall, so E commits at the same edge and its
    // result is exactly what the register would hold afterwards.
    assign hazard = 1'b0;
    assign op1 = rs1_hit ? alu_result : rs1_data;
    assign op2 = instr.instr_use_imm ? instr.instr_imm
               : (rs2_hit ? alu_result : rs2_data);
`else
    assign hazard = rs1_hit || rs2_hit;
    assign op1 = rs1_data;
    assign op2 = instr.instr_use_imm ? instr.instr_imm : rs2_data;
`endif

    assign instr.instr_ready = rst_n && !stall && !hazard;
    assign accept = instr.instr_valid && instr.instr_ready;
    assign commit = e_q.valid && !stall;

    always_comb begin
        e_d = e_q;
        if (accept) begin
            e_d.valid = 1'b1;
            e_d.op    = alu_op_t'(instr.instr_op);
            e_d.rd    = instr.instr_rd;
            e_d.op1   = op1;
            e_d.op2   = op2;
        end else if (commit) begin
            e_d.valid = 1'b0;
        end
        wb_valid_d = commit;
        wb_rd_d    = commit ? e_q.rd : '0;
        wb_data_d  = commit ? alu_result : '0;
        retire_d   = retire_q + {15'd0, commit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q        <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            retire_q   <= '0;
        end else begin
            e_q        <= e_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            retire_q   <= retire_d;
        end
    end

    assign alu_in1    = e_q.op1;
    assign alu_in2    = e_q.op2;
    assign alu_sel    = e_q.op;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign retire_cnt = retire_q;

endmodule
